// File: rtl/serial_rx.sv
// serial_rx: UART-style receiver for an 8N1 line (8E1 when SERIAL_RX_PARITY_EN is defined), LSB first.
// Latency: new_data/frame_err pulse 2 + CLK_PER_BIT/2 + 9*CLK_PER_BIT cycles after the start edge (+CLK_PER_BIT with parity).
// Backpressure: none; the line cannot be stalled, so each result is a single-cycle pulse that must be taken when seen.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   rx         raw serial line, idle high
//   data       last correctly received byte, held between new_data pulses
//   new_data   one-cycle pulse, data updated in the same cycle
//   frame_err  one-cycle pulse on a bad stop bit (or a bad even-parity bit when SERIAL_RX_PARITY_EN is defined)
//   busy       high from the accepted start edge until the frame is finished
//
// Optional build macro: SERIAL_RX_PARITY_EN adds a PARITY state and even-parity checking.
module serial_rx #(
    parameter int unsigned CLK_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       new_data,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] FULL_BIT = 16'(CLK_PER_BIT);
    localparam logic [15:0] HALF_BIT = 16'(CLK_PER_BIT / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_meta_d;
    logic        rx_s_q, rx_s_d;
    logic        armed_q, armed_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        new_data_q, new_data_d;
    logic        frame_err_q, frame_err_d;
`ifdef SERIAL_RX_PARITY_EN
    logic        par_err_q, par_err_d;
`endif
    logic        expire;

    // Two-flop synchronizer; nothing else looks at raw rx.
    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
    end

    // Counter reaches its last cycle: the sample point of the current bit.
    assign expire = (cnt_q == 16'd1);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            armed_q     <= 1'b0;
            cnt_q       <= 16'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            new_data_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            new_data_q  <= new_data_d;
            frame_err_q <= frame_err_d;
`ifdef SERIAL_RX_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        new_data_d  = 1'b0;
        frame_err_d = 1'b0;
        // A start is only accepted once the line has been seen high after reset,
        // so a line that is still low when reset releases is not taken as a start edge.
        armed_d     = armed_q | rx_s_q;
`ifdef SERIAL_RX_PARITY_EN
        par_err_d   = par_err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (armed_q && !rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_BIT;
                end
            end

            S_START: begin
                if (expire) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;       // glitch, not a real start bit
                    end else begin
                        state_d   = S_DATA;
                        cnt_d     = FULL_BIT;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end

            S_DATA: begin
                if (expire) begin
                    shift_d[bit_idx_q] = rx_s_q;
                    cnt_d              = FULL_BIT;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end

`ifdef SERIAL_RX_PARITY_EN
            S_PARITY: begin
                if (expire) begin
                    // Even parity: data plus parity bit must carry an even number of ones.
                    par_err_d = (^shift_q) ^ rx_s_q;
                    cnt_d     = FULL_BIT;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif

            S_STOP: begin
                if (expire) begin
                    if (rx_s_q) begin
`ifdef SERIAL_RX_PARITY_EN
                        if (par_err_q) begin
                            frame_err_d = 1'b1;
                        end else begin
                            data_d     = shift_q;
                            new_data_d = 1'b1;
                        end
`else
                        data_d     = shift_q;
                        new_data_d = 1'b1;
`endif
                        // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end

            S_WAIT_HIGH: begin
                // Line held low (break): wait for it to return high before hunting for a new start.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        busy      = (state_q != S_IDLE);
        data      = data_q;
        new_data  = new_data_q;
        frame_err = frame_err_q;
    end

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: randomized and directed frames for serial_rx, checked through a scoreboard queue.
// Latency: expected pulse cycle computed from the bit timing rules, with +/-1 cycle tolerance.
// Backpressure: none; the monitor pops one expectation per observed pulse.
module tb_serial_rx;

    localparam int CPB = 100;
`ifdef SERIAL_RX_PARITY_EN
    localparam int NB = 10;   // start-relative sample of the stop bit: 8 data + parity + stop
`else
    localparam int NB = 9;    // 8 data + stop
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       new_data;
    logic       frame_err;
    logic       busy;

    serial_rx #(.CLK_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .new_data  (new_data),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] val;
        int         at;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] ref_data    = 8'h00;
    bit         prev_pulse  = 1'b0;

    task automatic chk(input string name, input bit ok, input longint act, input longint req);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard; data must only move on new_data.
    always @(negedge clk) begin
        if (!rst) begin
            if (new_data || frame_err) begin
                chk("pulse_exclusive", !(new_data && frame_err), {new_data, frame_err}, 0);
                chk("pulse_one_cycle", !prev_pulse, 1, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 1'b0, {new_data, frame_err}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("pulse_kind", (frame_err == mon_e.is_err) && (new_data == !mon_e.is_err),
                        frame_err, mon_e.is_err);
                    chk("pulse_time", (cyc >= mon_e.at - 1) && (cyc <= mon_e.at + 1), cyc, mon_e.at);
                    if (!mon_e.is_err) ref_data = mon_e.val;
                end
            end
            chk("data_hold", data == ref_data, data, ref_data);
            prev_pulse = new_data || frame_err;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame; the expectation is queued at the start edge.
    // The pulse is due 2 + CPB/2 + NB*CPB cycles after the first clock edge that sees the start bit,
    // i.e. one more cycle counted from the cycle in which rx is driven low.
    task automatic send_frame(input logic [7:0] b, input bit stop, input bit bad_par, input int low_hold);
        exp_t e;
        e.is_err = !stop;
`ifdef SERIAL_RX_PARITY_EN
        e.is_err = e.is_err || bad_par;
`else
        if (bad_par) $display("note: parity request ignored in 8N1 build");
`endif
        e.val = b;
        e.at  = cyc + 3 + CPB / 2 + NB * CPB;
        sb.push_back(e);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
`ifdef SERIAL_RX_PARITY_EN
        rx = (^b) ^ bad_par;
        tick(CPB);
`endif
        rx = stop;
        tick(CPB);
        if (!stop) begin
            tick(low_hold);
            rx = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] rb;
        bit         rstop;
        bit         rpar;
        int         gap;
        int         w;
        int         t;

        // Reset state.
        rst = 1'b1;
        tick(3);
        chk("reset_data", data == 8'h00, data, 0);
        chk("reset_new_data", new_data == 1'b0, new_data, 0);
        chk("reset_frame_err", frame_err == 1'b0, frame_err, 0);
        chk("reset_busy", busy == 1'b0, busy, 0);
        rst = 1'b0;
        tick(5);

        // Single frame.
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        tick(20);
        chk("a5_data", data == 8'hA5, data, 8'hA5);
        chk("a5_idle", busy == 1'b0, busy, 0);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 1'b0, 0);
        send_frame(8'hFF, 1'b1, 1'b0, 0);
        tick(20);
        chk("b2b_data", data == 8'hFF, data, 8'hFF);

        // Short low glitch is not a start bit.
        t = cyc;
        rx = 1'b0;
        tick(10);
        chk("glitch_busy_high", busy == 1'b1, busy, 1);
        tick(20);
        rx = 1'b1;
        tick(32);
        chk("glitch_busy_low", busy == 1'b0, busy, 0);
        chk("glitch_no_pulse", sb.size() == 0, sb.size(), 0);
        tick(200);

        // Bad stop bit followed by a long break, then a good frame.
        fork
            send_frame(8'h3C, 1'b0, 1'b0, 3000);
            begin
                tick(NB * CPB + 1500);
                chk("break_busy_high", busy == 1'b1, busy, 1);
            end
        join
        chk("break_data_kept", data == 8'hFF, data, 8'hFF);
        tick(6);
        chk("break_busy_low", busy == 1'b0, busy, 0);
        send_frame(8'h12, 1'b1, 1'b0, 0);
        tick(20);
        chk("after_break_data", data == 8'h12, data, 8'h12);

        // Reset in the middle of bit 4 of 0x5A discards the frame.
        rb = 8'h5A;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = rb[i];
            tick(CPB);
        end
        rx = rb[4];
        tick(CPB / 2);
        rst = 1'b1;
        ref_data = 8'h00;
        tick(2);
        chk("midreset_data", data == 8'h00, data, 0);
        chk("midreset_busy", busy == 1'b0, busy, 0);
        rx = 1'b1;
        rst = 1'b0;
        tick(1500);
        chk("midreset_quiet", data == 8'h00, data, 0);
        send_frame(8'h81, 1'b1, 1'b0, 0);
        tick(20);
        chk("after_reset_data", data == 8'h81, data, 8'h81);

`ifdef SERIAL_RX_PARITY_EN
        // Wrong then right even parity on 0x07.
        send_frame(8'h07, 1'b1, 1'b1, 0);
        tick(20);
        chk("par_bad_data_kept", data == 8'h81, data, 8'h81);
        send_frame(8'h07, 1'b1, 1'b0, 0);
        tick(20);
        chk("par_good_data", data == 8'h07, data, 8'h07);
`endif

        // Randomized frames: random bytes, occasional bad stop bit / parity, random gaps.
        for (int n = 0; n < 30; n++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 5) != 0);
`ifdef SERIAL_RX_PARITY_EN
            rpar  = ($urandom_range(0, 4) == 0);
`else
            rpar  = 1'b0;
`endif
            send_frame(rb, rstop, rpar, $urandom_range(0, 300));
            gap = rstop ? $urandom_range(0, 40) : 4 + $urandom_range(0, 40);
            tick(gap);
        end

        // Drain the scoreboard with a bounded wait.
        w = 0;
        while (sb.size() != 0 && w < 5000) begin
            tick(1);
            w++;
        end
        chk("scoreboard_drained", sb.size() == 0, sb.size(), 0);
        tick(5);
        chk("final_idle", busy == 1'b0, busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
